// File: rtl/axi_rd_order_ctrl.sv
// Read-order controller: passes AR through with an outstanding-burst throttle and
// checks returning R beats against an in-order record of issued bursts.
module axi_rd_order_ctrl #(
    parameter int ID_WIDTH    = 4,
    parameter int LEN_WIDTH   = 8,
    parameter int DEPTH_WIDTH = 4,
    parameter int MAX_OUTST   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ID_WIDTH-1:0]    s_arid,
    input  logic [LEN_WIDTH-1:0]   s_arlen,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    output logic [ID_WIDTH-1:0]    m_arid,
    output logic [LEN_WIDTH-1:0]   m_arlen,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    input  logic [ID_WIDTH-1:0]    rid,
    input  logic                   rlast,
    input  logic                   rvalid,
    input  logic                   rready,
    input  logic                   clr_err,
    output logic [DEPTH_WIDTH:0]   outstanding,
    output logic                   idle,
    output logic                   err_id,
    output logic                   err_last,
    output logic                   err_unexp
);

    localparam int                   DEPTH    = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] MAX_CNT  = (DEPTH_WIDTH+1)'(MAX_OUTST);
    localparam logic [DEPTH_WIDTH:0] CNT_ONE  = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = DEPTH_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] BEAT_ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        logic [LEN_WIDTH-1:0] len;
    } entry_t;

    entry_t                 fifo_mem [DEPTH];
    entry_t                 head;
    state_t                 state_q, state_d;
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_WIDTH:0]   outstanding_q, outstanding_d;
    logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic                   err_id_q, err_id_d;
    logic                   err_last_q, err_last_d;
    logic                   err_unexp_q, err_unexp_d;

    logic full, ar_hs, r_hs, has_head, beat_ok, exp_last, pop;

    // The throttle looks only at registered state, so R inputs never reach AR outputs.
    assign full      = (outstanding_q == MAX_CNT);
    assign m_arid    = s_arid;
    assign m_arlen   = s_arlen;
    assign m_arvalid = s_arvalid & ~full;
    assign s_arready = m_arready & ~full;
    assign ar_hs     = m_arvalid & m_arready;
    assign r_hs      = rvalid & rready;

    assign outstanding = outstanding_q;
    assign idle        = (state_q == S_IDLE);
    assign err_id      = err_id_q;
    assign err_last    = err_last_q;
    assign err_unexp   = err_unexp_q;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        head     = fifo_mem[rd_ptr_q];
        has_head = (outstanding_q != '0);
        beat_ok  = r_hs & has_head;
        exp_last = (beat_cnt_q == head.len);
        pop      = beat_ok & exp_last;

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        beat_cnt_d    = beat_cnt_q;

        if (ar_hs) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({ar_hs, pop})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase

        // Burst completion follows the beat count; rlast is only checked.
        if (beat_ok) beat_cnt_d = exp_last ? '0 : beat_cnt_q + BEAT_ONE;

        if (outstanding_d == '0)    state_d = S_IDLE;
        else if (beat_cnt_d == '0)  state_d = S_WAIT;
        else                        state_d = S_BURST;

        // A new error in the clearing cycle still sets the flag.
        err_id_d    = (err_id_q    & ~clr_err) | (beat_ok & (rid != head.id));
        err_last_d  = (err_last_q  & ~clr_err) | (beat_ok & (rlast != exp_last));
        err_unexp_d = (err_unexp_q & ~clr_err) | (r_hs & ~has_head);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            beat_cnt_q    <= '0;
            err_id_q      <= 1'b0;
            err_last_q    <= 1'b0;
            err_unexp_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            beat_cnt_q    <= beat_cnt_d;
            err_id_q      <= err_id_d;
            err_last_q    <= err_last_d;
            err_unexp_q   <= err_unexp_d;
        end
    end

    // NOTE: the tracking storage is not reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (ar_hs) fifo_mem[wr_ptr_q] <= '{id: s_arid, len: s_arlen};
    end

endmodule
